// File: rtl/clk_div_pkg.sv
// +--------------------------------------------------------------------+
// | clk_div_pkg : shared types and helpers for the clk_div_multi block  |
// | Optional feature macro (users): CLK_DIV_MULTI_SYNC_EN              |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

package clk_div_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } ch_state_e;

   function automatic int cfg_ch_w(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_ch.sv
// +--------------------------------------------------------------------+
// | clk_div_ch : one divider channel (counter, state, div/pdiv)        |
// | Optional macro CLK_DIV_MULTI_SYNC_EN adds i_sync_rst phase align    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int CNT_W   = 25,
   parameter int DIV_RST = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_upd,
   input  logic [CNT_W-1:0] i_div,
`ifdef CLK_DIV_MULTI_SYNC_EN
   input  logic             i_sync_rst,
`endif
   output logic             o_clk_out,
   output logic             o_tick,
   output logic             o_pend
);

   localparam logic [CNT_W-1:0] C_DIV_INIT = CNT_W'(DIV_RST);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pdiv_q, pdiv_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             w_wrap;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      pdiv_d    = pdiv_q;
      clk_out_d = clk_out_q;
      tick_d    = tick_q;
      w_wrap    = (cnt_q == div_q);

      if (!i_en) begin
         // A same-cycle update wins over committing the old pending value.
         state_d   = ST_OFF;
         cnt_d     = '0;
         clk_out_d = 1'b0;
         tick_d    = 1'b0;
         if (i_upd)
            div_d = i_div;
         else if (state_q == ST_PEND)
            div_d = pdiv_q;
      end
`ifdef CLK_DIV_MULTI_SYNC_EN
      else if (i_sync_rst) begin
         state_d   = ST_RUN;
         cnt_d     = '0;
         clk_out_d = 1'b0;
         tick_d    = 1'b0;
         if (state_q == ST_PEND)
            div_d = pdiv_q;
      end
`endif
      else if (state_q == ST_OFF) begin
         state_d   = ST_RUN;
         cnt_d     = '0;
         clk_out_d = 1'b0;
         tick_d    = 1'b0;
         if (i_upd)
            div_d = i_div;
      end else begin
         if (w_wrap) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = 1'b1;
            if (state_q == ST_PEND) begin
               div_d   = pdiv_q;
               state_d = ST_RUN;
            end
         end else begin
            cnt_d  = cnt_q + 1'b1;
            tick_d = 1'b0;
         end
         if (i_upd) begin
            pdiv_d  = i_div;
            state_d = ST_PEND;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_OFF;
         cnt_q     <= '0;
         div_q     <= C_DIV_INIT;
         pdiv_q    <= C_DIV_INIT;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         pdiv_q    <= pdiv_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign o_clk_out = clk_out_q;
   assign o_tick    = tick_q;
   assign o_pend    = (state_q == ST_PEND);

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// +--------------------------------------------------------------------+
// | clk_div_multi : NCH independent programmable clock dividers        |
// | Optional macro CLK_DIV_MULTI_SYNC_EN adds the sync_rst input        |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int  NCH     = 4,
   parameter int  CNT_W   = 25,
   parameter int  DIV_RST = 32,
   localparam int C_CH_W  = cfg_ch_w(NCH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH-1:0]    en,
   input  logic              cfg_valid,
   input  logic [C_CH_W-1:0] cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLK_DIV_MULTI_SYNC_EN
   input  logic              sync_rst,
`endif
   output logic              cfg_ready,
   output logic [NCH-1:0]    clk_out,
   output logic [NCH-1:0]    tick
);

   logic [NCH-1:0] w_pend;
   logic [NCH-1:0] w_upd;

   // Out-of-range channel numbers leave cfg_ready high and decode to nothing.
   always_comb begin
      cfg_ready = 1'b1;
      w_upd     = '0;
      for (int i = 0; i < NCH; i++) begin
         if (int'(cfg_ch) == i) begin
            cfg_ready = ~w_pend[i];
            w_upd[i]  = cfg_valid & ~w_pend[i];
         end
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      clk_div_ch #(
         .CNT_W   (CNT_W),
         .DIV_RST (DIV_RST)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_en       (en[i]),
         .i_upd      (w_upd[i]),
         .i_div      (cfg_div),
`ifdef CLK_DIV_MULTI_SYNC_EN
         .i_sync_rst (sync_rst),
`endif
         .o_clk_out  (clk_out[i]),
         .o_tick     (tick[i]),
         .o_pend     (w_pend[i])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// +--------------------------------------------------------------------+
// | tb_clk_div_multi : directed + random bench for clk_div_multi       |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_clk_div_multi;

   localparam int NCH     = 4;
   localparam int CNT_W   = 8;
   localparam int DIV_RST = 32;
   localparam int CH_W    = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NCH-1:0]   en;
   logic             cfg_valid;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic             sync_rst;
   logic             cfg_ready;
   logic [NCH-1:0]   clk_out;
   logic [NCH-1:0]   tick;

   int checks = 0;
   int errors = 0;

   // Reference model: each running channel is described by the absolute
   // edge number of its next wrap rather than by a counter.
   logic           m_on   [NCH];
   int             m_div  [NCH];
   int             m_pdiv [NCH];
   logic           m_pend [NCH];
   int             m_nwrap[NCH];
   logic [NCH-1:0] m_clk;
   logic [NCH-1:0] m_tick;
   int             edge_n = 0;

   always #5 clk = ~clk;

   clk_div_multi #(
      .NCH     (NCH),
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
`ifdef CLK_DIV_MULTI_SYNC_EN
      .sync_rst  (sync_rst),
`endif
      .cfg_ready (cfg_ready),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_on[i]   = 1'b0;
         m_div[i]  = DIV_RST;
         m_pdiv[i] = DIV_RST;
         m_pend[i] = 1'b0;
      end
      m_clk  = '0;
      m_tick = '0;
   endtask

   function automatic logic exp_ready();
      if (int'(cfg_ch) >= NCH) return 1'b1;
      return !m_pend[cfg_ch];
   endfunction

   task automatic model_edge(input logic acc);
      for (int i = 0; i < NCH; i++) begin
         logic up;
         up = acc && (int'(cfg_ch) == i);
         if (!en[i]) begin
            m_on[i] = 1'b0; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
            if (up) m_div[i] = int'(cfg_div);
            else if (m_pend[i]) m_div[i] = m_pdiv[i];
            m_pend[i] = 1'b0;
         end
`ifdef CLK_DIV_MULTI_SYNC_EN
         else if (sync_rst) begin
            m_on[i] = 1'b1; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
            if (m_pend[i]) m_div[i] = m_pdiv[i];
            m_pend[i]  = 1'b0;
            m_nwrap[i] = edge_n + m_div[i] + 1;
         end
`endif
         else if (!m_on[i]) begin
            m_on[i] = 1'b1; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
            if (up) m_div[i] = int'(cfg_div);
            m_nwrap[i] = edge_n + m_div[i] + 1;
         end else begin
            if (edge_n == m_nwrap[i]) begin
               m_tick[i] = 1'b1;
               m_clk[i]  = ~m_clk[i];
               if (m_pend[i]) begin
                  m_div[i]  = m_pdiv[i];
                  m_pend[i] = 1'b0;
               end
               m_nwrap[i] = edge_n + m_div[i] + 1;
            end else begin
               m_tick[i] = 1'b0;
            end
            if (up) begin
               m_pdiv[i] = int'(cfg_div);
               m_pend[i] = 1'b1;
            end
         end
      end
      edge_n++;
   endtask

   // Entered just after a falling edge with inputs already driven.
   task automatic cycle();
      logic er;
      #1;
      er = exp_ready();
      checks++;
      assert (cfg_ready === er) else begin
         errors++;
         $error("FAIL cfg_ready edge=%0d observed=%b expected=%b", edge_n, cfg_ready, er);
      end
      @(posedge clk);
      model_edge(cfg_valid && er);
      @(negedge clk);
      checks++;
      assert (clk_out === m_clk) else begin
         errors++;
         $error("FAIL clk_out edge=%0d observed=%b expected=%b", edge_n, clk_out, m_clk);
      end
      checks++;
      assert (tick === m_tick) else begin
         errors++;
         $error("FAIL tick edge=%0d observed=%b expected=%b", edge_n, tick, m_tick);
      end
   endtask

   // Number of cycles until clk_out[ch] shows a rising transition.
   task automatic cycles_to_rise(input int ch, output int k);
      logic prev;
      prev = clk_out[ch];
      k = 0;
      for (int n = 0; n < 200; n++) begin
         cycle();
         k++;
         if (clk_out[ch] && !prev) break;
         prev = clk_out[ch];
      end
   endtask

   task automatic cfg_write(input int ch, input int dv);
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_div   = CNT_W'(dv);
      cycle();
      cfg_valid = 1'b0;
   endtask

   initial begin
      int k;
      rst_n = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; sync_rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_clk_out", int'(clk_out), 0);
      chk("reset_tick", int'(tick), 0);
      chk("reset_ready", int'(cfg_ready), 1);
      rst_n = 1'b1;

      // Default divisor on channel 0 only.
      en = 4'b0001;
      cycles_to_rise(0, k);
      chk("ch0_first_rise", k - 1, 33);
      cycles_to_rise(0, k);
      chk("ch0_period", k, 66);

      // Channel 1: div 3, retarget to 1 while counting.
      cfg_write(1, 3);
      en = 4'b0011;
      cycle();
      cycle();
      cfg_write(1, 1);
      cfg_ch = 2'd1;
      #1 chk("ch1_ready_drop", int'(cfg_ready), 0);
      k = 0;
      for (int n = 0; n < 20 && !tick[1]; n++) begin cycle(); k++; end
      chk("ch1_old_period_end", k, 2);
      k = 0;
      for (int n = 0; n < 20; n++) begin cycle(); k++; if (tick[1]) break; end
      chk("ch1_new_tick_spacing", k, 2);

      // Channel 2: div 0.
      cfg_write(2, 0);
      en = 4'b0111;
      repeat (4) cycle();
      chk("ch2_tick_high", int'(tick[2]), 1);

      // Channel 0: pend, then disable, then re-enable.
      cfg_write(0, 5);
      cfg_ch = 2'd0;
      #1 chk("ch0_pend_ready", int'(cfg_ready), 0);
      en[0] = 1'b0;
      cycle();
      chk("ch0_off_clk", int'(clk_out[0]), 0);
      chk("ch0_off_ready", int'(cfg_ready), 1);
      en[0] = 1'b1;
      cycles_to_rise(0, k);
      chk("ch0_new_div_rise", k - 1, 6);

      // Asynchronous reset in the middle of a period.
      cfg_write(3, 2);
      en = 4'b1111;
      repeat (5) cycle();
      #2 rst_n = 1'b0;
      #1 chk("async_rst_clk_out", int'(clk_out), 0);
      chk("async_rst_tick", int'(tick), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycles_to_rise(1, k);
      chk("ch1_div_after_rst", k - 1, 33);

      // Random traffic with small divisors.
      for (int ch = 0; ch < NCH; ch++) begin
         en = '0;
         cfg_write(ch, $urandom_range(0, 5));
      end
      en = 4'b1111;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NCH; i++)
            if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
         cfg_valid = ($urandom_range(0, 2) == 0);
         cfg_ch    = CH_W'($urandom_range(0, NCH - 1));
         cfg_div   = CNT_W'($urandom_range(0, 6));
         cycle();
      end
      cfg_valid = 1'b0;

`ifdef CLK_DIV_MULTI_SYNC_EN
      en = '0;
      cycle();
      cfg_write(0, 4);
      cfg_write(1, 9);
      en = 4'b0011;
      repeat (7) cycle();
      sync_rst = 1'b1;
      cycle();
      sync_rst = 1'b0;
      cycles_to_rise(1, k);
      chk("sync_ch1_rise", k, 10);
      repeat (30) cycle();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
